// File: rtl/cpu_ctrl.sv
// cpu_ctrl: six-state fetch/decode/execute sequencer for an 8-opcode accumulator CPU
module cpu_ctrl #(
    parameter int         CNT_W = 8,
    parameter logic [2:0] NOP   = 3'b000,
    parameter logic [2:0] LDO   = 3'b001,
    parameter logic [2:0] LDA   = 3'b010,
    parameter logic [2:0] STO   = 3'b011,
    parameter logic [2:0] PRE   = 3'b100,
    parameter logic [2:0] ADD   = 3'b101,
    parameter logic [2:0] LDM   = 3'b110,
    parameter logic [2:0] HLT   = 3'b111
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic [2:0]       opcode,
    input  logic             mem_rdy,
    output logic             rd,
    output logic             wr,
    output logic             ir_ld_hi,
    output logic             ir_ld_lo,
    output logic             inc_pc,
    output logic             load_acc,
    output logic             datactl_ena,
    output logic [2:0]       alu_op,
    output logic             halt,
    output logic [CNT_W-1:0] instr_cnt
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH1 = 3'd1;
    localparam logic [2:0] S_FETCH2 = 3'd2;
    localparam logic [2:0] S_DECODE = 3'd3;
    localparam logic [2:0] S_EXEC   = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    logic [2:0] state, state_nx, op_q;
    logic       retire, exec_rd, exec_wr;

    // Retirement points and next-state selection; an instruction boundary follows ena
    always_comb begin
        retire   = (state == S_DECODE && (opcode == NOP || opcode == LDM)) || (state == S_EXEC && mem_rdy);
        state_nx = state;
        case (state)
            S_IDLE:   state_nx = ena ? S_FETCH1 : S_IDLE;
            S_FETCH1: state_nx = mem_rdy ? S_FETCH2 : S_FETCH1;
            S_FETCH2: state_nx = mem_rdy ? S_DECODE : S_FETCH2;
            S_DECODE: state_nx = opcode == HLT ? S_HALT : retire ? (ena ? S_FETCH1 : S_IDLE) : S_EXEC;
            S_EXEC:   state_nx = retire ? (ena ? S_FETCH1 : S_IDLE) : S_EXEC;
            S_HALT:   state_nx = S_HALT;
            default:  state_nx = S_IDLE;
        endcase
    end

    // Strobes are decoded from state (and mem_rdy for single-cycle pulses); IDLE after reset zeroes them all
    always_comb begin
        exec_rd     = state == S_EXEC && (op_q == LDO || op_q == LDA || op_q == PRE || op_q == ADD);
        exec_wr     = state == S_EXEC && op_q == STO;
        rd          = state == S_FETCH1 || state == S_FETCH2 || exec_rd;
        wr          = exec_wr;
        datactl_ena = exec_wr;
        ir_ld_hi    = state == S_FETCH1 && mem_rdy;
        ir_ld_lo    = state == S_FETCH2 && mem_rdy;
        inc_pc      = (state == S_FETCH1 || state == S_FETCH2) && mem_rdy;
        load_acc    = exec_rd && mem_rdy;
        alu_op      = state == S_EXEC ? op_q : NOP;
        halt        = state == S_HALT;
    end

    // State, latched opcode and retired-instruction counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            op_q      <= NOP;
            instr_cnt <= '0;
        end else begin
            state <= state_nx;
            if (state == S_DECODE) op_q <= opcode;
            if (retire) instr_cnt <= instr_cnt + 1'b1;
        end
    end
endmodule
